led_multi_ctrl: RTL and testbench

LED_MULTI_CTRL -- requirements
Module: led_multi_ctrl

---
 rtl/led_ctrl_pkg.sv | 16 +
 rtl/led_channel.sv | 128 ++++++++++++
 rtl/led_multi_ctrl.sv | 92 +++++++++
 tb/tb_led_multi_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared LED mode encodings and width helper for led_multi_ctrl
package led_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_ON      = 2'b01,
      MODE_BLINK   = 2'b10,
      MODE_BREATHE = 2'b11
   } mode_t;

   // Index width that never collapses to zero bits for a count of one.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/led_channel.sv
// rtl/led_channel.sv - one LED channel: mode, rate, phase, blink level and breathe duty
// Breathe logic is present only with LED_MULTI_CTRL_BREATHE_EN; otherwise mode 11 behaves as ON.
module led_channel
   import led_ctrl_pkg::*;
#(
   parameter int PWM_BITS  = 8,
   parameter int RATE_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  mode_t                mode_in,
   input  logic [RATE_BITS-1:0] rate_in,
   input  logic                 tick,
`ifdef LED_MULTI_CTRL_BREATHE_EN
   input  logic [PWM_BITS-1:0]  pwm,
`endif
   output logic                 led
);

   mode_t                mode_q, mode_d;
   logic [RATE_BITS-1:0] rate_q, rate_d;
   logic [RATE_BITS-1:0] phase_q, phase_d;
   logic                 level_q, level_d;
   logic                 led_d;
   logic                 step;

`ifdef LED_MULTI_CTRL_BREATHE_EN
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
   localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);

   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [PWM_BITS-1:0] pwm_next;
   logic                down_q, down_d;

   // led is registered, so compare against the PWM value that will be current after this edge.
   assign pwm_next = pwm + DUTY_ONE;
`endif

   always_comb begin
      mode_d  = mode_q;
      rate_d  = rate_q;
      phase_d = phase_q;
      level_d = level_q;
      step    = 1'b0;
      led_d   = 1'b0;
`ifdef LED_MULTI_CTRL_BREATHE_EN
      duty_d  = duty_q;
      down_d  = down_q;
`endif
      if (we) begin
         mode_d  = mode_in;
         rate_d  = rate_in;
         phase_d = '0;
         level_d = 1'b1;
`ifdef LED_MULTI_CTRL_BREATHE_EN
         duty_d  = '0;
         down_d  = 1'b0;
`endif
      end else if (tick) begin
         if (phase_q == rate_q) begin
            phase_d = '0;
            step    = 1'b1;
         end else begin
            phase_d = phase_q + RATE_BITS'(1);
         end
         if (step && mode_q == MODE_BLINK) begin
            level_d = ~level_q;
         end
`ifdef LED_MULTI_CTRL_BREATHE_EN
         // Triangle sweep: reverse at either end so the extreme value is never repeated.
         if (step && mode_q == MODE_BREATHE) begin
            if (!down_q) begin
               if (duty_q == DUTY_MAX) begin
                  duty_d = duty_q - DUTY_ONE;
                  down_d = 1'b1;
               end else begin
                  duty_d = duty_q + DUTY_ONE;
               end
            end else begin
               if (duty_q == '0) begin
                  duty_d = duty_q + DUTY_ONE;
                  down_d = 1'b0;
               end else begin
                  duty_d = duty_q - DUTY_ONE;
               end
            end
         end
`endif
      end

      case (mode_d)
         MODE_OFF:   led_d = 1'b0;
         MODE_ON:    led_d = 1'b1;
         MODE_BLINK: led_d = level_d;
`ifdef LED_MULTI_CTRL_BREATHE_EN
         default:    led_d = (pwm_next < duty_d);
`else
         default:    led_d = 1'b1;
`endif
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= MODE_OFF;
         rate_q  <= '0;
         phase_q <= '0;
         level_q <= 1'b0;
         led     <= 1'b0;
`ifdef LED_MULTI_CTRL_BREATHE_EN
         duty_q  <= '0;
         down_q  <= 1'b0;
`endif
      end else begin
         mode_q  <= mode_d;
         rate_q  <= rate_d;
         phase_q <= phase_d;
         level_q <= level_d;
         led     <= led_d;
`ifdef LED_MULTI_CTRL_BREATHE_EN
         duty_q  <= duty_d;
         down_q  <= down_d;
`endif
      end
   end

endmodule

// File: rtl/led_multi_ctrl.sv
// rtl/led_multi_ctrl.sv - multi-channel LED controller: tick prescaler, shared PWM counter, config port
// BREATHE mode and the PWM counter exist only with LED_MULTI_CTRL_BREATHE_EN defined.
module led_multi_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int CHANNELS  = 4,
   parameter int TICK_DIV  = 25000,
   parameter int PWM_BITS  = 8,
   parameter int RATE_BITS = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                cfg_we,
   input  logic [clog2_min1(CHANNELS)-1:0]     cfg_ch,
   input  logic [1:0]                          cfg_mode,
   input  logic [RATE_BITS-1:0]                cfg_rate,
   output logic                                cfg_ack,
   output logic                                cfg_err,
   output logic [CHANNELS-1:0]                 led
);

   localparam int               CH_W     = clog2_min1(CHANNELS);
   localparam int               PRE_W    = clog2_min1(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);

   logic [PRE_W-1:0] pre_cnt;
   logic             tick;
   logic             ch_valid;

   assign tick     = (pre_cnt == PRE_LAST);
   assign ch_valid = ({1'b0, cfg_ch} < CH_LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_ack <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         cfg_ack <= cfg_we;
         cfg_err <= cfg_we && !ch_valid;
      end
   end

`ifdef LED_MULTI_CTRL_BREATHE_EN
   logic [PWM_BITS-1:0] pwm_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
   end
`else
   // PWM_BITS only sizes breathe logic; this empty block keeps it referenced in the default build.
   if (PWM_BITS < 1) begin : g_pwm_bits_unused
   end
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic ch_we;

      assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

      led_channel #(
         .PWM_BITS  (PWM_BITS),
         .RATE_BITS (RATE_BITS)
      ) u_channel (
         .clk     (clk),
         .rst     (rst),
         .we      (ch_we),
         .mode_in (mode_t'(cfg_mode)),
         .rate_in (cfg_rate),
         .tick    (tick),
`ifdef LED_MULTI_CTRL_BREATHE_EN
         .pwm     (pwm_cnt),
`endif
         .led     (led[i])
      );
   end

endmodule

// File: tb/tb_led_multi_ctrl.sv
// tb/tb_led_multi_ctrl.sv - directed self-checking bench for led_multi_ctrl (CHANNELS=3, TICK_DIV=4, PWM_BITS=4, RATE_BITS=4)
`timescale 1ns/1ps
module tb_led_multi_ctrl;

   localparam int CHANNELS  = 3;
   localparam int TICK_DIV  = 4;
   localparam int PWM_BITS  = 4;
   localparam int RATE_BITS = 4;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       cfg_we   = 1'b0;
   logic [1:0] cfg_ch   = 2'd0;
   logic [1:0] cfg_mode = 2'd0;
   logic [3:0] cfg_rate = 4'd0;
   logic       cfg_ack;
   logic       cfg_err;
   logic [2:0] led;

   int cyc    = 0;
   int n_chk  = 0;
   int n_fail = 0;

   led_multi_ctrl #(
      .CHANNELS  (CHANNELS),
      .TICK_DIV  (TICK_DIV),
      .PWM_BITS  (PWM_BITS),
      .RATE_BITS (RATE_BITS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_mode (cfg_mode),
      .cfg_rate (cfg_rate),
      .cfg_ack  (cfg_ack),
      .cfg_err  (cfg_err),
      .led      (led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // cyc counts edges since reset release; ticks land on edges where cyc % 4 == 0.
   task automatic clk_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic cfg_write(input int ch, input logic [1:0] mode, input logic [3:0] rate);
      cfg_we   = 1'b1;
      cfg_ch   = ch[1:0];
      cfg_mode = mode;
      cfg_rate = rate;
      clk_step();
      cfg_we   = 1'b0;
   endtask

   // ch0 BLINK R=1 written at edge 2: toggles at edges 8, 16, 24, ...
   function automatic logic blink0(input int c);
      return ((c / 8) % 2) == 0;
   endfunction

   // ch2 BLINK R=0 written at tick edge 12: first toggle at 16, then every 4 edges.
   function automatic logic blink2(input int c);
      return (((c - 12) / 4) % 2) == 0;
   endfunction

   function automatic int duty_at(input int k);
      if (k <= 15)      return k;
      else if (k <= 30) return 30 - k;
      else              return k - 30;
   endfunction

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_led", led, 0);
      chk("rst_ack", cfg_ack, 0);
      chk("rst_err", cfg_err, 0);
      rst = 1'b0;
      cyc = 0;

      clk_step();
      cfg_write(0, 2'b10, 4'd1);
      chk("blink_ack", cfg_ack, 1);
      chk("blink_err", cfg_err, 0);
      chk("blink_led", led, 3'b001);
      while (cyc < 9) begin
         clk_step();
         chk("blink_run", led, {2'b00, blink0(cyc)});
         chk("ack_low", cfg_ack, 0);
      end

      cfg_write(3, 2'b01, 4'd0);
      chk("err_ack", cfg_ack, 1);
      chk("err_err", cfg_err, 1);
      chk("err_led", led, {2'b00, blink0(cyc)});
      clk_step();
      chk("err_ack_drop", cfg_ack, 0);
      chk("err_led_after", led, {2'b00, blink0(cyc)});

      cfg_write(2, 2'b10, 4'd0);
      chk("coll_ack", cfg_ack, 1);
      chk("coll_led", led, {blink2(cyc), 1'b0, blink0(cyc)});
      while (cyc < 31) begin
         clk_step();
         chk("coll_run", led, {blink2(cyc), 1'b0, blink0(cyc)});
      end

      cfg_write(1, 2'b01, 4'd0);
      chk("b2b_ack1", cfg_ack, 1);
      chk("b2b_led1", led, {blink2(cyc), 1'b1, blink0(cyc)});
      cfg_write(2, 2'b00, 4'd0);
      chk("b2b_ack2", cfg_ack, 1);
      chk("b2b_err2", cfg_err, 0);
      chk("b2b_led2", led, {1'b0, 1'b1, blink0(cyc)});
      while (cyc < 40) begin
         clk_step();
         chk("b2b_run", led, {1'b0, 1'b1, blink0(cyc)});
      end

`ifdef LED_MULTI_CTRL_BREATHE_EN
      cfg_write(1, 2'b11, 4'd0);
      chk("breathe_ack", cfg_ack, 1);
      chk("breathe_err", cfg_err, 0);
      chk("breathe_led0", led, {1'b0, 1'b0, blink0(cyc)});
      while (cyc < 181) begin
         clk_step();
         chk("breathe_run", led, {1'b0, ((cyc % 16) < duty_at(cyc / 4 - 10)), blink0(cyc)});
      end
`else
      cfg_write(0, 2'b11, 4'd0);
      chk("mode3_ack", cfg_ack, 1);
      chk("mode3_err", cfg_err, 0);
      chk("mode3_led", led, 3'b011);
      repeat (20) begin
         clk_step();
         chk("mode3_run", led, 3'b011);
      end
`endif

      cfg_write(0, 2'b10, 4'd1);
      chk("reblink_ack", cfg_ack, 1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_led", led, 0);
      chk("midrst_ack", cfg_ack, 0);
      chk("midrst_err", cfg_err, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) begin
         clk_step();
         chk("postrst_led", led, 0);
         chk("postrst_ack", cfg_ack, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
